pipe_field: RTL

//  Next-generation pipe generator for Flappy Bird. Drives NUM_PIPES staggered pipe channels

---
 rtl/pipe_field.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_field.sv
// Purpose: staggered Flappy Bird pipe generator; moves NUM_PIPES channels left, LFSR gap heights, score pulse.
// Latency: all outputs registered; launch/move/respawn land one Clk after the tick, ScorePulse one Clk after the crossing tick.
// Backpressure: none; Pause freezes the prescaler and positions, Stop freezes everything until Start. Optional: PIPE_SPEEDUP_EN.
module pipe_field #(
  parameter int NUM_PIPES = 3,
  parameter int POS_W     = 10,
  parameter int TICK_DIV  = 500000,
  parameter int X_START   = 1000,
  parameter int X_SPACING = 350,
  parameter int X_OFF     = 1023,
  parameter int Y_BASE    = 75,
  parameter int BIRD_X    = 200
`ifdef PIPE_SPEEDUP_EN
  ,
  parameter int SPEEDUP_EVERY = 5,
  parameter int STEP_MAX      = 4
`endif
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Stop,
  input  logic                       Pause,
  output logic [NUM_PIPES*POS_W-1:0] PipePosX,
  output logic [NUM_PIPES*POS_W-1:0] PipePosY,
  output logic [NUM_PIPES-1:0]       Active,
  output logic                       ScorePulse,
  output logic [1:0]                 State
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LOST  = 2'b11
  } state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [POS_W-1:0] L_X_START  = POS_W'(X_START);
  localparam logic [POS_W-1:0] L_X_OFF    = POS_W'(X_OFF);
  localparam logic [POS_W-1:0] L_Y_BASE   = POS_W'(Y_BASE);
  localparam logic [POS_W-1:0] L_BIRD_X   = POS_W'(BIRD_X);
  // Predecessor position at or below which the next channel launches.
  localparam logic [POS_W-1:0] L_LAUNCH_X = POS_W'(X_START - X_SPACING);

  state_t               r_state, w_state_nx;
  logic [CNT_W-1:0]     r_cnt;
  logic [7:0]           r_lfsr, w_lfsr_nx;
  logic [POS_W-1:0]     r_x [NUM_PIPES];
  logic [POS_W-1:0]     r_y [NUM_PIPES];
  logic [POS_W-1:0]     w_x_nx [NUM_PIPES];
  logic [POS_W-1:0]     w_y_nx [NUM_PIPES];
  logic [NUM_PIPES-1:0] r_act, w_act_nx;
  logic                 r_score;
  logic                 w_pass, w_launched, w_run, w_tick;
  logic [POS_W-1:0]     w_step;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  function automatic logic [7:0] f_lfsr_shift(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // The prescaler only advances in RUN cycles that are not leaving RUN.
  assign w_run  = (r_state == S_RUN) && !Stop && !Pause;
  assign w_tick = w_run && (r_cnt == CNT_W'(TICK_DIV - 1));

`ifdef PIPE_SPEEDUP_EN
  localparam int SPD_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  logic [SPD_W-1:0] r_spd_cnt;
  logic [POS_W-1:0] r_step;

  // Count score pulses; every SPEEDUP_EVERY-th one bumps the step up to STEP_MAX.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_spd_cnt <= '0;
      r_step    <= POS_W'(1);
    end else if (r_state == S_IDLE || (r_state == S_LOST && Start)) begin
      r_spd_cnt <= '0;
      r_step    <= POS_W'(1);
    end else if (w_tick && w_pass) begin
      if (r_spd_cnt == SPD_W'(SPEEDUP_EVERY - 1)) begin
        r_spd_cnt <= '0;
        if (r_step < POS_W'(STEP_MAX)) r_step <= r_step + POS_W'(1);
      end else begin
        r_spd_cnt <= r_spd_cnt + SPD_W'(1);
      end
    end
  end
  assign w_step = r_step;
`else
  assign w_step = POS_W'(1);
`endif

  // Game state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state decode; Stop outranks Pause, Start only matters in IDLE and LOST.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nx = S_RUN;
      S_RUN:   if (Stop) w_state_nx = S_LOST; else if (Pause) w_state_nx = S_PAUSE;
      S_PAUSE: if (Stop) w_state_nx = S_LOST; else if (!Pause) w_state_nx = S_RUN;
      S_LOST:  if (Start) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Per-tick channel update in channel order, each respawn/launch taking the next LFSR value.
  always_comb begin
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_act_nx   = r_act;
    w_lfsr_nx  = r_lfsr;
    w_pass     = 1'b0;
    w_launched = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (r_act[i]) begin
        // X < step+1 means the next move would reach or cross zero: respawn instead.
        if (r_x[i] <= w_step) begin
          w_x_nx[i] = L_X_START;
          w_y_nx[i] = L_Y_BASE + POS_W'(w_lfsr_nx);
          w_lfsr_nx = f_lfsr_shift(w_lfsr_nx);
        end else begin
          w_x_nx[i] = r_x[i] - w_step;
          if (r_x[i] > L_BIRD_X && w_x_nx[i] <= L_BIRD_X) w_pass = 1'b1;
        end
      end else if (i > 0 && !w_launched && w_act_nx[(i > 0) ? i - 1 : 0] &&
                   w_x_nx[(i > 0) ? i - 1 : 0] <= L_LAUNCH_X) begin
        w_x_nx[i]   = L_X_START;
        w_y_nx[i]   = L_Y_BASE + POS_W'(w_lfsr_nx);
        w_act_nx[i] = 1'b1;
        w_lfsr_nx   = f_lfsr_shift(w_lfsr_nx);
        w_launched  = 1'b1;
      end
    end
  end

  // Datapath: LFSR free-runs in IDLE, channels move on ticks in RUN, LOST+Start clears the field.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_lfsr  <= 8'hA5;
      r_act   <= '0;
      r_score <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i] <= L_X_OFF;
        r_y[i] <= L_Y_BASE;
      end
    end else begin
      r_score <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_lfsr <= f_lfsr_shift(r_lfsr);
          r_cnt  <= '0;
          if (Start) begin
            r_x[0]   <= L_X_START;
            r_y[0]   <= L_Y_BASE + POS_W'(r_lfsr);
            r_act[0] <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_act   <= w_act_nx;
            r_lfsr  <= w_lfsr_nx;
            r_score <= w_pass;
          end else if (w_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOST: begin
          if (Start) begin
            r_act <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
              r_x[i] <= L_X_OFF;
              r_y[i] <= L_Y_BASE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PIPES; g++) begin : g_pack
      assign PipePosX[g*POS_W +: POS_W] = r_x[g];
      assign PipePosY[g*POS_W +: POS_W] = r_y[g];
    end
  endgenerate

  assign Active     = r_act;
  assign ScorePulse = r_score;
  assign State      = r_state;

endmodule
